// File: rtl/alu_module.sv
// Registered two-operand ALU (AND/OR/ADD/SUB) with a (word_length+1)-bit result and zero flag.
// The result MSB carries the add carry-out or the subtract borrow.
module alu_module #(
  parameter int word_length = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [word_length-1:0] A,
  input  logic [word_length-1:0] B,
  input  logic [1:0]             ALU_control,
  output logic [word_length:0]   C,
  output logic                   zero_flag
);

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_ADD = 2'b10,
    OP_SUB = 2'b11
  } alu_op_e;

  logic [word_length:0] c_next;

  always_comb begin
    // NOTE: default assignment first so no path through the case leaves c_next unassigned (no latch).
    c_next = '0;
    case (alu_op_e'(ALU_control))
      OP_OR:   c_next = {1'b0, A | B};
      OP_ADD:  c_next = {1'b0, A} + {1'b0, B};
      // Zero-extended subtract wraps mod 2^(N+1), so the MSB is set exactly when A < B.
      OP_SUB:  c_next = {1'b0, A} - {1'b0, B};
      default: c_next = {1'b0, A & B};
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments for all registered state so every flop samples pre-edge values.
    if (rst) begin
      C         <= '0;
      zero_flag <= 1'b1;
    end else begin
      C         <= c_next;
      zero_flag <= (c_next == '0);
    end
  end

endmodule

// File: tb/tb_alu_module.sv
// Scoreboard bench for alu_module: the driver queues expected results, a monitor
// pops and compares one cycle later, after each rising clk edge.
module tb_alu_module;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [1:0]   ALU_control;
  logic [W:0]   C;
  logic         zero_flag;

  typedef struct {
    logic [W:0] c;
    logic       z;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  alu_module #(.word_length(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .A           (A),
    .B           (B),
    .ALU_control (ALU_control),
    .C           (C),
    .zero_flag   (zero_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Independent reference: borrow computed by comparison, not by wide subtraction.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic [1:0] ctl);
    logic [W:0] r;
    case (ctl)
      2'b00:   r = {1'b0, a & b};
      2'b01:   r = {1'b0, a | b};
      2'b10:   r = (W+1)'(a) + (W+1)'(b);
      default: r = {(a < b), W'(a - b)};
    endcase
    return r;
  endfunction

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] ctl,
                       input logic [W:0] exp_c, input string name);
    exp_t e;
    @(negedge clk);
    A = a;
    B = b;
    ALU_control = ctl;
    e.c = exp_c;
    e.z = (exp_c == '0);
    e.name = name;
    exp_q.push_back(e);
  endtask

  // Monitor: the result of the previous sample is valid 1 time unit after every edge.
  always @(posedge clk) begin : monitor
    exp_t e;
    #1;
    if (!rst && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({e.name, " C"}, C, e.c);
      check({e.name, " zero_flag"}, {{W{1'b0}}, zero_flag}, {{W{1'b0}}, e.z});
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin : driver
    logic [W-1:0] ra, rb;
    logic [1:0]   rc;
    int           wait_cycles;

    rst = 1'b0;
    A = '0;
    B = '0;
    ALU_control = 2'b00;

    // Asynchronous reset before any clock edge.
    #1 rst = 1'b1;
    #1;
    check("reset_async C", C, '0);
    check("reset_async zero_flag", {{W{1'b0}}, zero_flag}, {{W{1'b0}}, 1'b1});
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_hold C", C, '0);
    check("reset_hold zero_flag", {{W{1'b0}}, zero_flag}, {{W{1'b0}}, 1'b1});

    // Directed vectors, hand-computed.
    issue(8'h0D, 8'h08, 2'b00, 9'h008, "and_0d_08");
    issue(8'h0D, 8'h08, 2'b10, 9'h015, "add_0d_08");
    issue(8'hFF, 8'h01, 2'b10, 9'h100, "add_ff_01");
    issue(8'hFF, 8'hFF, 2'b10, 9'h1FE, "add_ff_ff");
    issue(8'h00, 8'h00, 2'b10, 9'h000, "add_00_00");
    issue(8'h0D, 8'h08, 2'b11, 9'h005, "sub_0d_08");
    issue(8'h08, 8'h0D, 2'b11, 9'h1FB, "sub_08_0d");
    issue(8'h03, 8'h05, 2'b11, 9'h1FE, "sub_03_05");
    issue(8'h00, 8'h01, 2'b11, 9'h1FF, "sub_00_01");
    issue(8'h55, 8'h55, 2'b11, 9'h000, "sub_55_55");
    issue(8'hF0, 8'h0F, 2'b01, 9'h0FF, "or_f0_0f");

    // Inputs changed mid-cycle must not disturb the registered result.
    @(posedge clk);
    #3;
    A = 8'h12;
    B = 8'h34;
    ALU_control = 2'b10;
    #1;
    check("between_edges C", C, 9'h0FF);
    issue(8'hF0, 8'h0F, 2'b00, 9'h000, "and_f0_0f");
    issue(8'hAA, 8'h55, 2'b00, 9'h000, "and_aa_55");
    issue(8'hC3, 8'h81, 2'b00, 9'h081, "and_c3_81");

    // Random run against the model, with an asynchronous reset pulse mid-stream.
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 2'($urandom_range(0, 3));
      issue(ra, rb, rc, model(ra, rb, rc), $sformatf("rand_%0d", i));
      if (i == 500) begin
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("reset_midrun C", C, '0);
        check("reset_midrun zero_flag", {{W{1'b0}}, zero_flag}, {{W{1'b0}}, 1'b1});
        exp_q.delete();
        #1 rst = 1'b0;
        #1;
        check("reset_release_hold C", C, '0);
      end
    end

    // Drain the scoreboard within a bounded number of cycles.
    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 5) begin
      @(posedge clk);
      #2;
      wait_cycles++;
    end
    check("scoreboard_drained", (W+1)'(exp_q.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
